// File: rtl/proc_seq_pkg.sv
// Shared encodings and defaults for the processor run-control sequencer.
// State values are fixed because they are exported on the state debug port.
package proc_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DUMP  = 3'd4,
        S_DONE  = 3'd5
    } seq_state_e;

    // syscall encoding; fetching it ends the run
    localparam logic [31:0] HALT_WORD_DEFAULT = 32'h0000000C;

    localparam int RF_NUM_REGS = 32;

    // Five-stage pipeline: up to four instructions are still in flight behind the halting fetch.
    localparam int DRAIN_CYCLES_DEFAULT = 4;

endpackage

// File: rtl/proc_sequencer.sv
// Run-control sequencer: streams a program into instruction memory, runs the datapath
// until halt/end-of-program/timeout, drains the pipeline and dumps the register file.
module proc_sequencer
    import proc_seq_pkg::*;
#(
    parameter int               ADDR_W       = 8,
    parameter int               CYC_W        = 16,
    parameter logic [CYC_W-1:0] MAX_CYCLES   = 16'hFFFF,
    parameter int               DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT,
    parameter logic [31:0]      HALT_WORD    = HALT_WORD_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] prog_len,
    input  logic              ld_valid,
    input  logic [31:0]       ld_data,
    output logic              ld_ready,
    output logic              imem_wr_en,
    output logic              imem_rd_en,
    output logic [31:0]       imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              init_mode,
    output logic              pc_reset,
    output logic              pc_write,
    input  logic [31:0]       pc_value,
    input  logic [31:0]       instruction,
    output logic              dbg_override,
    output logic [4:0]        dbg_reg_sel,
    input  logic [31:0]       reg_rd_data,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [4:0]        dump_idx,
    output logic [31:0]       dump_value,
    output logic [CYC_W-1:0]  cycle_count,
    output logic [2:0]        state,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic              error
);

    localparam int               DRAIN_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);
    localparam logic [CYC_W-1:0] CYC_LAST   = MAX_CYCLES - 1'b1;
    localparam logic [4:0]       DUMP_LAST  = 5'(RF_NUM_REGS - 1);

    seq_state_e          r_state;
    logic [ADDR_W-1:0]   r_prog_len;
    logic [ADDR_W-1:0]   r_load_idx;
    logic [4:0]          r_dump_idx;
    logic [CYC_W-1:0]    r_cycle_count;
    logic [DRAIN_W-1:0]  r_drain_cnt;
    logic                r_timeout;
    logic                r_error;

    logic [31:0]         w_len_bytes;
    logic                w_halt;
    logic                w_cyc_last;
    logic                w_in_load;
    logic                w_in_init;

    assign w_len_bytes = {{(30-ADDR_W){1'b0}}, r_prog_len, 2'b00};
    assign w_halt      = (instruction == HALT_WORD) || (pc_value >= w_len_bytes);
    assign w_cyc_last  = (r_cycle_count == CYC_LAST);
    assign w_in_load   = (r_state == S_LOAD);
    assign w_in_init   = (r_state == S_IDLE) || (r_state == S_LOAD) || (r_state == S_DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_prog_len    <= '0;
            r_load_idx    <= '0;
            r_dump_idx    <= '0;
            r_cycle_count <= '0;
            r_drain_cnt   <= '0;
            r_timeout     <= 1'b0;
            r_error       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_load_idx    <= '0;
                        r_dump_idx    <= '0;
                        r_cycle_count <= '0;
                        r_drain_cnt   <= '0;
                        r_timeout     <= 1'b0;
                        if (prog_len != '0) begin
                            r_prog_len <= prog_len;
                            r_error    <= 1'b0;
                            r_state    <= S_LOAD;
                        end else begin
                            r_error    <= 1'b1;
                            r_state    <= S_DONE;
                        end
                    end
                end
                S_LOAD: begin
                    if (ld_valid) begin
                        r_load_idx <= r_load_idx + 1'b1;
                        if (r_load_idx == r_prog_len - 1'b1) begin
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    r_cycle_count <= r_cycle_count + 1'b1;
                    // timeout wins when it coincides with a halt condition
                    if (w_cyc_last) begin
                        r_timeout <= 1'b1;
                        r_state   <= S_DRAIN;
                    end else if (w_halt) begin
                        r_state   <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (r_drain_cnt == DRAIN_LAST) begin
                        r_drain_cnt <= '0;
                        r_state     <= S_DUMP;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 1'b1;
                    end
                end
                S_DUMP: begin
                    if (dump_ready) begin
                        r_dump_idx <= r_dump_idx + 1'b1;
                        if (r_dump_idx == DUMP_LAST) begin
                            r_state <= S_DONE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // All controls decode from the state register; only the memory write also looks at ld_valid.
    assign ld_ready     = w_in_load;
    assign imem_wr_en   = w_in_load & ld_valid;
    assign imem_addr    = {{(30-ADDR_W){1'b0}}, r_load_idx, 2'b00};
    assign imem_wdata   = ld_data;
    assign imem_rd_en   = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign init_mode    = w_in_init;
    assign pc_reset     = w_in_init;
    assign pc_write     = (r_state == S_RUN);
    assign dbg_override = (r_state == S_DUMP);
    assign dbg_reg_sel  = r_dump_idx;
    assign dump_valid   = (r_state == S_DUMP);
    assign dump_idx     = r_dump_idx;
    assign dump_value   = reg_rd_data;
    assign cycle_count  = r_cycle_count;
    assign state        = r_state;
    assign busy         = !((r_state == S_IDLE) || (r_state == S_DONE));
    assign done         = (r_state == S_DONE);
    assign timeout      = r_timeout;
    assign error        = r_error;

endmodule

// File: tb/tb_proc_sequencer.sv
// Bench for proc_sequencer: a toy datapath (PC, instruction memory, register file with
// addi/beq) surrounds the DUT; a program-level interpreter predicts run length and dump.
module tb_proc_sequencer;

    localparam int          TB_MAX   = 16;
    localparam int          TB_DRAIN = 4;
    localparam logic [31:0] HALT     = 32'h0000000C;
    localparam logic [2:0]  ST_IDLE  = 3'd0;
    localparam logic [2:0]  ST_RUN   = 3'd2;
    localparam logic [2:0]  ST_DRAIN = 3'd3;
    localparam logic [2:0]  ST_DUMP  = 3'd4;
    localparam logic [2:0]  ST_DONE  = 3'd5;

    logic        clk, reset, start, ld_valid, dump_ready;
    logic [7:0]  prog_len;
    logic [31:0] ld_data, pc_value, instruction, reg_rd_data;
    logic        ld_ready, imem_wr_en, imem_rd_en, init_mode, pc_reset, pc_write;
    logic        dbg_override, dump_valid, busy, done, timeout, error;
    logic [31:0] imem_addr, imem_wdata, dump_value;
    logic [4:0]  dbg_reg_sel, dump_idx;
    logic [15:0] cycle_count;
    logic [2:0]  state;

    proc_sequencer #(.MAX_CYCLES(16'd16)) dut (
        .clk(clk), .reset(reset), .start(start), .prog_len(prog_len),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .imem_wr_en(imem_wr_en), .imem_rd_en(imem_rd_en), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .init_mode(init_mode), .pc_reset(pc_reset),
        .pc_write(pc_write), .pc_value(pc_value), .instruction(instruction),
        .dbg_override(dbg_override), .dbg_reg_sel(dbg_reg_sel), .reg_rd_data(reg_rd_data),
        .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_idx(dump_idx),
        .dump_value(dump_value), .cycle_count(cycle_count), .state(state), .busy(busy),
        .done(done), .timeout(timeout), .error(error)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time budget exceeded");
        $fatal(1, "watchdog");
    end

    // ---------------- toy datapath ----------------
    logic [31:0] imem [0:255];
    logic [31:0] rf   [0:31];
    logic [31:0] tb_pc;
    logic        clr_mem;

    assign pc_value    = tb_pc;
    assign instruction = imem[tb_pc[9:2]];
    assign reg_rd_data = dbg_override ? rf[dbg_reg_sel] : rf[instruction[20:16]];

    always @(posedge clk) begin
        if (clr_mem) begin
            for (int i = 0; i < 256; i++) imem[i] <= 32'h0;
            for (int i = 0; i < 32; i++) rf[i] <= 32'h0;
        end else if (imem_wr_en && init_mode) begin
            imem[imem_addr[9:2]] <= imem_wdata;
        end
        if (pc_reset) begin
            tb_pc <= 32'h0;
        end else if (pc_write) begin
            if (instruction[31:26] == 6'd8) begin
                if (instruction[20:16] != 5'd0)
                    rf[instruction[20:16]] <= rf[instruction[25:21]] + {{16{instruction[15]}}, instruction[15:0]};
                tb_pc <= tb_pc + 32'd4;
            end else if (instruction[31:26] == 6'd4 && rf[instruction[25:21]] == rf[instruction[20:16]]) begin
                tb_pc <= tb_pc + 32'd4 + {{14{instruction[15]}}, instruction[15:0], 2'b00};
            end else begin
                tb_pc <= tb_pc + 32'd4;
            end
        end
    end

    // ---------------- scoreboard state ----------------
    int          checks, failures;
    logic [31:0] prog [0:255];
    int          plen;
    logic [31:0] exp_regs [0:31];
    int          exp_cycles;
    logic        exp_timeout;
    logic [63:0] exp_q[$];

    // Program-level interpreter: one fetch per RUN cycle, stop on HALT, past-end PC or budget.
    task automatic compute_ref();
        int pc, cyc, off;
        logic [31:0] w;
        for (int i = 0; i < 32; i++) exp_regs[i] = 32'h0;
        pc = 0; cyc = 0; exp_timeout = 1'b0;
        while (cyc < TB_MAX) begin
            cyc++;
            w = (pc < plen) ? prog[pc] : 32'h0;
            if (w == HALT || pc >= plen) begin
                exp_timeout = (cyc == TB_MAX);
                break;
            end
            off = int'($signed(w[15:0]));
            if (w[31:26] == 6'd8) begin
                if (w[20:16] != 5'd0) exp_regs[w[20:16]] = exp_regs[w[25:21]] + 32'(off);
                pc = pc + 1;
            end else if (w[31:26] == 6'd4 && exp_regs[w[25:21]] == exp_regs[w[20:16]]) begin
                pc = pc + 1 + off;
            end else begin
                pc = pc + 1;
            end
            if (cyc == TB_MAX) exp_timeout = 1'b1;
        end
        exp_cycles = cyc;
    endtask

    task automatic clear_mem();
        @(negedge clk); clr_mem = 1'b1;
        @(negedge clk); clr_mem = 1'b0;
    endtask

    // vmode: 0 valid always, 1 valid every other cycle, 2 random; rmode: 0 ready always,
    // 1 ready low for 3 cycles at index 7, 2 random.
    task automatic run_session(input int vmode, input int rmode, input string tag);
        int sent, guard, run_cyc, drain_cyc, idx, stall;
        logic v, r;
        if (state !== ST_IDLE && state !== ST_DONE) begin
            reset = 1'b1; #2; reset = 1'b0;
        end
        clear_mem();
        compute_ref();
        exp_q.delete();
        for (int k = 0; k < plen; k++) exp_q.push_back({32'(k * 4), prog[k]});
        @(negedge clk); start = 1'b1; prog_len = plen[7:0]; ld_valid = 1'b0;

        sent = 0; guard = 0;
        while (sent < plen && guard < 400) begin
            @(negedge clk);
            start = 1'($urandom_range(0, 1)); prog_len = 8'($urandom);
            case (vmode)
                0: v = 1'b1;
                1: v = (guard % 2) == 1;
                default: v = 1'($urandom_range(0, 1));
            endcase
            ld_valid = v; ld_data = v ? prog[sent] : $urandom; #1;
            checks++;
            if ({ld_ready, imem_wr_en, init_mode, pc_reset} !== {1'b1, v, 1'b1, 1'b1}) begin
                failures++;
                $display("FAIL %s load_ctrl got=%b exp=%b", tag, {ld_ready, imem_wr_en, init_mode, pc_reset}, {1'b1, v, 1'b1, 1'b1});
            end
            if (v) begin
                checks++;
                if ({imem_addr, imem_wdata} !== exp_q[0]) begin
                    failures++;
                    $display("FAIL %s load_write got=%h exp=%h", tag, {imem_addr, imem_wdata}, exp_q[0]);
                end
                void'(exp_q.pop_front());
                sent++;
            end
            guard++;
        end
        checks++;
        if (sent != plen) begin
            failures++;
            $display("FAIL %s load_budget got=%0d exp=%0d words", tag, sent, plen);
        end

        run_cyc = 0; guard = 0;
        while (guard < 200) begin
            @(negedge clk);
            start = 1'($urandom_range(0, 1)); ld_valid = 1'($urandom_range(0, 1)); ld_data = $urandom; #1;
            if (state !== ST_RUN) break;
            checks++;
            if ({ld_ready, imem_wr_en, pc_reset, pc_write, imem_rd_en, init_mode, busy} !== 7'b0001101) begin
                failures++;
                $display("FAIL %s run_ctrl got=%b exp=%b", tag, {ld_ready, imem_wr_en, pc_reset, pc_write, imem_rd_en, init_mode, busy}, 7'b0001101);
            end
            run_cyc++; guard++;
        end
        ld_valid = 1'b0;
        checks++;
        if (run_cyc != exp_cycles) begin
            failures++;
            $display("FAIL %s run_cycles got=%0d exp=%0d", tag, run_cyc, exp_cycles);
        end
        checks++;
        if ({state, timeout, cycle_count} !== {ST_DRAIN, exp_timeout, 16'(exp_cycles)}) begin
            failures++;
            $display("FAIL %s drain_entry got=%h exp=%h", tag, {state, timeout, cycle_count}, {ST_DRAIN, exp_timeout, 16'(exp_cycles)});
        end

        drain_cyc = 0; guard = 0;
        while (state === ST_DRAIN && guard < 50) begin
            checks++;
            if ({pc_write, imem_rd_en, pc_reset} !== 3'b010) begin
                failures++;
                $display("FAIL %s drain_ctrl got=%b exp=%b", tag, {pc_write, imem_rd_en, pc_reset}, 3'b010);
            end
            drain_cyc++; guard++;
            @(negedge clk); start = 1'($urandom_range(0, 1)); #1;
        end
        checks++;
        if (drain_cyc != TB_DRAIN) begin
            failures++;
            $display("FAIL %s drain_cycles got=%0d exp=%0d", tag, drain_cyc, TB_DRAIN);
        end

        idx = 0; stall = 0; guard = 0;
        while (idx < 32 && guard < 400) begin
            case (rmode)
                0: r = 1'b1;
                1: if (idx == 7 && stall < 3) begin r = 1'b0; stall++; end else r = 1'b1;
                default: r = 1'($urandom_range(0, 1));
            endcase
            dump_ready = r; #1;
            checks++;
            if ({state, dump_valid, dbg_override, dbg_reg_sel, dump_idx, dump_value} !==
                {ST_DUMP, 2'b11, 5'(idx), 5'(idx), exp_regs[idx]}) begin
                failures++;
                $display("FAIL %s dump_word got=%h exp=%h", tag, {state, dump_valid, dbg_override, dbg_reg_sel, dump_idx, dump_value},
                         {ST_DUMP, 2'b11, 5'(idx), 5'(idx), exp_regs[idx]});
            end
            if (r) idx++;
            guard++;
            @(negedge clk); start = 1'($urandom_range(0, 1)); #1;
        end
        start = 1'b0; dump_ready = 1'b0;
        checks++;
        if (idx != 32) begin
            failures++;
            $display("FAIL %s dump_handshakes got=%0d exp=32", tag, idx);
        end
        checks++;
        if ({state, done, busy, timeout, error, cycle_count, pc_reset, init_mode, dump_valid} !==
            {ST_DONE, 1'b1, 1'b0, exp_timeout, 1'b0, 16'(exp_cycles), 1'b1, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL %s done_state got=%h exp=%h", tag, {state, done, busy, timeout, error, cycle_count, pc_reset, init_mode, dump_valid},
                     {ST_DONE, 1'b1, 1'b0, exp_timeout, 1'b0, 16'(exp_cycles), 1'b1, 1'b1, 1'b0});
        end
        for (int k = 0; k < plen; k++) begin
            checks++;
            if (imem[k] !== prog[k]) begin
                failures++;
                $display("FAIL %s imem_content[%0d] got=%h exp=%h", tag, k, imem[k], prog[k]);
            end
        end
    endtask

    task automatic load_directed();
        prog[0] = 32'h20100002; prog[1] = 32'h22100003; prog[2] = HALT; plen = 3;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (2) @(negedge clk);
        ld_valid = 1'b1; #1;
        checks++;
        if ({state, pc_reset, init_mode, ld_ready, imem_wr_en, pc_write, imem_rd_en} !== {ST_IDLE, 6'b110000}) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=%b", {state, pc_reset, init_mode, ld_ready, imem_wr_en, pc_write, imem_rd_en}, {ST_IDLE, 6'b110000});
        end
        checks++;
        if ({dbg_override, dump_valid, busy, done, timeout, error, cycle_count, dump_idx} !== 27'd0) begin
            failures++;
            $display("FAIL reset_flags got=%h exp=0", {dbg_override, dump_valid, busy, done, timeout, error, cycle_count, dump_idx});
        end
        reset = 1'b0; ld_valid = 1'b0;
    endtask

    task automatic test_directed();
        load_directed();
        run_session(0, 0, "directed");
    endtask

    task automatic test_load_toggle();
        load_directed();
        run_session(1, 0, "load_toggle");
    endtask

    task automatic test_no_halt();
        prog[0] = 32'h20080007; prog[1] = 32'h20090009; plen = 2;
        run_session(0, 0, "no_halt");
    endtask

    task automatic test_timeout();
        prog[0] = 32'h1000FFFF; plen = 1;
        run_session(0, 2, "timeout");
    endtask

    task automatic test_error();
        @(negedge clk); start = 1'b1; prog_len = 8'd0;
        @(negedge clk); start = 1'b0; #1;
        checks++;
        if ({state, error, done, timeout, busy, cycle_count} !== {ST_DONE, 4'b1100, 16'd0}) begin
            failures++;
            $display("FAIL error_start got=%h exp=%h", {state, error, done, timeout, busy, cycle_count}, {ST_DONE, 4'b1100, 16'd0});
        end
    endtask

    task automatic test_dump_stall();
        load_directed();
        run_session(0, 1, "dump_stall");
    endtask

    task automatic test_mid_run_reset();
        clear_mem();
        prog[0] = 32'h1000FFFF; plen = 1;
        @(negedge clk); start = 1'b1; prog_len = 8'd1;
        @(negedge clk); start = 1'b0; ld_valid = 1'b1; ld_data = prog[0];
        @(negedge clk); ld_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({state, cycle_count} !== {ST_RUN, 16'd3}) begin
            failures++;
            $display("FAIL midrun_pre got=%h exp=%h", {state, cycle_count}, {ST_RUN, 16'd3});
        end
        #1; reset = 1'b1; #1;
        checks++;
        if ({state, pc_reset, init_mode, pc_write, busy, done, timeout, error, cycle_count} !== {ST_IDLE, 7'b1100000, 16'd0}) begin
            failures++;
            $display("FAIL midrun_reset got=%h exp=%h", {state, pc_reset, init_mode, pc_write, busy, done, timeout, error, cycle_count},
                     {ST_IDLE, 7'b1100000, 16'd0});
        end
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_random();
        for (int s = 0; s < 6; s++) begin
            plen = $urandom_range(1, 12);
            for (int k = 0; k < plen; k++)
                prog[k] = {6'd8, 5'($urandom_range(0, 31)), 5'($urandom_range(1, 31)), 16'($urandom)};
            if ($urandom_range(0, 1) == 1) prog[$urandom_range(0, plen - 1)] = HALT;
            run_session(2, 2, "random");
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        reset = 1'b1; start = 1'b0; prog_len = 8'd0; ld_valid = 1'b0; ld_data = 32'h0;
        dump_ready = 1'b0; clr_mem = 1'b0;
        test_reset();
        test_directed();
        test_load_toggle();
        test_no_halt();
        test_timeout();
        test_error();
        test_dump_stall();
        test_mid_run_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
